inst_fetch_unit: RTL
====================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter IW, default 36, instruction width in bits.
REQ-002 Parameter AW, default 10, instruction-memory address width; depth = 2^AW.
REQ-003 Parameter CW, default 16, width of the delivered-instruction counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  instruction-memory write strobe.
REQ-007 wr_addr  input  AW  write address.
REQ-008 wr_data  input  IW  write data.
REQ-009 start  input  1  begin fetch sequence; sampled only in IDLE.
REQ-010 start_pc  input  AW  first fetch address, captured with start.
REQ-011 end_pc  input  AW  last fetch address, captured with start.
REQ-012 loop_en  input  1  1 = restart at start_pc after end_pc; captured with start.
REQ-013 abort  input  1  terminate sequence and flush.
REQ-014 m_data  output  IW  instruction beat.
REQ-015 m_valid  output  1  m_data valid.
REQ-016 m_ready  input  1  consumer accepts the beat when m_valid=1.
REQ-017 busy  output  1  1 whenever state is not IDLE.
REQ-018 done  output  1  one-cycle pulse when a non-looping sequence completes.
REQ-019 wr_err  output  1  one-cycle pulse when wr_en arrives outside IDLE.
REQ-020 beat_cnt  output  CW  beats accepted since last start; wraps modulo 2^CW.

Function
REQ-021 Memory: 2^AW x IW array, one synchronous write port, one synchronous read port with 1-cycle read latency; contents not reset.
REQ-022 Write is performed only in IDLE; wr_en in RUN/DRAIN is dropped, no memory change, and wr_err pulses the next cycle.
REQ-023 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-024 IDLE->RUN when start=1 and abort=0; pc<=start_pc; end_pc and loop_en latched; beat_cnt<=0.
REQ-025 start outside IDLE is ignored.
REQ-026 Output buffer: 2-entry FIFO; a read is issued in a cycle only if (FIFO occupancy + reads in flight) < 2.
REQ-027 After each issued read, pc<=pc+1 modulo 2^AW (address 2^AW-1 wraps to 0; end_pc < start_pc is legal).
REQ-028 Read issued at pc==end_pc: if loop_en=1, pc<=start_pc and stay RUN; else RUN->DRAIN with no further reads.
REQ-029 DRAIN->IDLE when FIFO empty and no read in flight; done=1 for exactly that transition cycle.
REQ-030 abort=1 in any state: next cycle state IDLE, FIFO emptied, in-flight read discarded, m_valid=0, done stays 0; abort has priority over start.
REQ-031 m_valid = FIFO not empty; m_data = FIFO head; m_data held stable while m_valid=1 and m_ready=0.
REQ-032 Beat transfer when m_valid and m_ready both 1; beat_cnt increments by 1 per transfer.
REQ-033 Latency: start sampled at edge E0 -> read issued at E1 -> m_valid=1 after E2 with m_data=mem[start_pc].
REQ-034 With m_ready held 1, throughput is one beat per cycle with no bubbles.
REQ-035 Order of delivered beats equals address order start_pc..end_pc (repeated when looping), none duplicated or dropped under any m_ready pattern.

Reset
REQ-036 While rst_n=0: state IDLE, pc=0, FIFO empty, in-flight cleared, m_valid=0, busy=0, done=0, wr_err=0, beat_cnt=0, m_data=0.
REQ-037 Reset mid-sequence behaves as REQ-036 immediately (asynchronous) with no done pulse; memory contents retained.

Verification
REQ-038 Load mem[0..7]=0x100+i, start_pc=2, end_pc=5, loop_en=0, m_ready=1 -> beats 0x102,0x103,0x104,0x105 on consecutive cycles, first 2 cycles after E0 per REQ-033, then done pulse once, beat_cnt=4, busy=0.
REQ-039 Same load, m_ready toggling 1,0,0,1,... -> identical beat sequence, m_data stable during stalls, no loss/duplication.
REQ-040 start_pc=2^AW-2, end_pc=1, loop_en=0 -> beats from addresses 1022,1023,0,1 (AW=10), then done.
REQ-041 start_pc=0, end_pc=2, loop_en=1, m_ready=1 for 9 beats then abort -> 0,1,2,0,1,2,0,1,2; after abort m_valid=0, busy=0, no done.
REQ-042 wr_en=1 to addr 3 while busy -> wr_err pulses, later sequence over addr 3 returns the old value.
REQ-043 rst_n deasserted mid-RUN with m_valid=1 -> all outputs per REQ-036 immediately; following start fetches correctly from retained memory.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit.
// Streams instructions from an on-chip instruction memory, walking addresses
// start_pc..end_pc (wrapping modulo 2^AW), optionally looping, and delivers
// them through a 2-entry output FIFO with a valid/ready handshake.
// The memory can be loaded through the write port only while the unit is idle.

module inst_fetch_unit #(
   parameter int IW = 36,
   parameter int AW = 10,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [IW-1:0] wr_data,
   input  logic          start,
   input  logic [AW-1:0] start_pc,
   input  logic [AW-1:0] end_pc,
   input  logic          loop_en,
   input  logic          abort,
   output logic [IW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          busy,
   output logic          done,
   output logic          wr_err,
   output logic [CW-1:0] beat_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Instruction storage and its registered read port.
   logic [IW-1:0] mem [2**AW];
   logic [IW-1:0] rd_q;
   logic          rd_issue;
   logic          rd_inflight;

   // Sequence context captured with start.
   logic [AW-1:0] pc;
   logic [AW-1:0] start_q;
   logic [AW-1:0] end_q;
   logic          loop_q;

   // Output FIFO.
   logic [IW-1:0] fifo_q [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    fifo_cnt;
   logic          push;
   logic          pop;

   // Occupancy plus reads in flight, net of this cycle's pop.
   logic [2:0]    credit_used;

   logic          idle;
   logic          accept_start;
   logic [CW-1:0] beat_q;
   logic          wr_err_q;

   assign idle         = (state == S_IDLE);
   assign accept_start = idle && start && !abort;

   assign m_valid  = (fifo_cnt != 2'd0);
   assign m_data   = fifo_q[rd_ptr];
   assign busy     = !idle;
   assign wr_err   = wr_err_q;
   assign beat_cnt = beat_q;

   assign pop  = m_valid && m_ready;
   assign push = rd_inflight;

   // A pop in the same cycle frees a slot for the read being issued now; this
   // is what lets a latency-1 memory sustain one beat per cycle into 2 entries.
   assign credit_used = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};

   // Next-state, read-issue and done decode.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch can be inferred.
      state_nxt = state;
      rd_issue  = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (credit_used < 3'd2) begin
               rd_issue = 1'b1;
               if ((pc == end_q) && !loop_q) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((fifo_cnt == 2'd0) && !rd_inflight) begin
               state_nxt = S_IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort wins over everything, including start and completion.
      if (abort) begin
         state_nxt = S_IDLE;
         rd_issue  = 1'b0;
         done      = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Instruction memory: write only while idle, registered read when issued.
   always_ff @(posedge clk) begin
      // NOTE: the memory array and read register are deliberately not reset; rd_inflight qualifies rd_q.
      if (wr_en && idle) mem[wr_addr] <= wr_data;
      if (rd_issue)      rd_q         <= mem[pc];
   end

   // Read-in-flight flag; an abort discards the outstanding read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_inflight <= 1'b0;
      else        rd_inflight <= rd_issue && !abort;
   end

   // Fetch address and captured sequence context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= '0;
         start_q <= '0;
         end_q   <= '0;
         loop_q  <= 1'b0;
      end else if (accept_start) begin
         pc      <= start_pc;
         start_q <= start_pc;
         end_q   <= end_pc;
         loop_q  <= loop_en;
      end else if (rd_issue) begin
         if ((pc == end_q) && loop_q) pc <= start_q;
         else                         pc <= pc + 1'b1;
      end
   end

   // Output FIFO: filled from the memory read register, drained by the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else if (abort) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= rd_q;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // Accepted-beat counter, cleared when a new sequence starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            beat_q <= '0;
      else if (accept_start) beat_q <= '0;
      else if (pop)          beat_q <= beat_q + 1'b1;
   end

   // Write-error pulse for writes attempted while a sequence is active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_err_q <= 1'b0;
      else        wr_err_q <= wr_en && !idle;
   end

endmodule
